// File: rtl/periodic_tx_scheduler.sv
// periodic_tx_scheduler
//   Turns the timer tick into per-slot periodic CAN transmit requests.
//   Each slot counts ticks down from its programmed period. When the count
//   expires, the slot becomes pending. Pending slots are granted round-robin
//   over a valid/ready handshake. A slot that fires again while still pending
//   sets a sticky overrun flag.
//   Optional feature: define PTX_OVERRUN_CNT_EN to add overrun_cnt[7:0].
//   overrun_cnt is a saturating global count of cycles with any overrun.
module periodic_tx_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int PERIOD_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [PERIOD_W-1:0]          cfg_period,
  input  logic                         cfg_en,
  output logic                         req_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] req_slot,
  input  logic                         req_ready,
  output logic [NUM_SLOTS-1:0]         overrun
`ifdef PTX_OVERRUN_CNT_EN
  ,
  output logic [7:0]                   overrun_cnt
`endif
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    req_slot_q, req_slot_d;
  logic [SLOT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOTS-1:0] en_q, en_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [NUM_SLOTS-1:0] overrun_q, overrun_d;
  logic [PERIOD_W-1:0]  period_q [NUM_SLOTS];
  logic [PERIOD_W-1:0]  period_d [NUM_SLOTS];
  logic [PERIOD_W-1:0]  count_q  [NUM_SLOTS];
  logic [PERIOD_W-1:0]  count_d  [NUM_SLOTS];

  logic                 handshake;
  logic [SLOT_W-1:0]    sel_slot;
  logic                 sel_found;
  logic [SLOT_W:0]      scan_idx;
  logic                 fire;
  logic                 granted;
`ifdef PTX_OVERRUN_CNT_EN
  logic                 ovr_event;
  logic [7:0]           ovr_cnt_q, ovr_cnt_d;
`endif

  assign handshake = (state_q == S_REQ) && req_ready;

  // Round-robin pick: first pending slot at or above rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sel_slot  = '0;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (SLOT_W + 1)'(k);
      if (scan_idx >= (SLOT_W + 1)'(NUM_SLOTS)) begin
        scan_idx = scan_idx - (SLOT_W + 1)'(NUM_SLOTS);
      end
      if (!sel_found && pending_q[scan_idx[SLOT_W-1:0]]) begin
        sel_found = 1'b1;
        sel_slot  = scan_idx[SLOT_W-1:0];
      end
    end
  end

  // Per-slot tick countdown, fire, pending and overrun tracking.
  // A config write to a slot takes priority over its tick.
  always_comb begin
    en_d      = en_q;
    period_d  = period_q;
    count_d   = count_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    fire      = 1'b0;
    granted   = 1'b0;
`ifdef PTX_OVERRUN_CNT_EN
    ovr_event = 1'b0;
`endif
    for (int i = 0; i < NUM_SLOTS; i++) begin
      granted = handshake && (req_slot_q == SLOT_W'(i));
      fire    = 1'b0;
      if (cfg_we && (cfg_slot == SLOT_W'(i))) begin
        period_d[i]  = cfg_period;
        en_d[i]      = cfg_en;
        count_d[i]   = cfg_period;
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end else begin
        if (tick && en_q[i] && (period_q[i] != '0)) begin
          if (count_q[i] == PERIOD_W'(1)) begin
            count_d[i] = period_q[i];
            fire       = 1'b1;
          end else if (count_q[i] > PERIOD_W'(1)) begin
            count_d[i] = count_q[i] - PERIOD_W'(1);
          end
        end
        if (fire) begin
          // A re-fire of the slot being granted right now re-arms it cleanly.
          pending_d[i] = 1'b1;
          if (pending_q[i] && !granted) begin
            overrun_d[i] = 1'b1;
`ifdef PTX_OVERRUN_CNT_EN
            ovr_event    = 1'b1;
`endif
          end
        end else if (granted) begin
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  // Request FSM: hold valid/slot stable in REQ until the handshake.
  always_comb begin
    state_d    = state_q;
    req_slot_d = req_slot_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d    = S_REQ;
          req_slot_d = sel_slot;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = (req_slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0
                                                           : req_slot_q + SLOT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PTX_OVERRUN_CNT_EN
  // Saturating count of cycles in which at least one slot overran.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_event && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  // Overrun counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q    <= S_IDLE;
      req_slot_q <= '0;
      rr_ptr_q   <= '0;
      en_q       <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      // NOTE: the slot tables are reset because reset must leave every
      // slot with period=0 and count=0; they are small register arrays.
      period_q   <= '{default: '0};
      count_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      req_slot_q <= req_slot_d;
      rr_ptr_q   <= rr_ptr_d;
      en_q       <= en_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      period_q   <= period_d;
      count_q    <= count_d;
    end
  end

  assign req_valid = (state_q == S_REQ);
  assign req_slot  = req_slot_q;
  assign overrun   = overrun_q;

endmodule
